seq_logic_unit: RTL and testbench

Parametrised, multi-cycle bitwise logic unit for the ALU datapath. It generalises the fixed 16-bit AND in width and operation set, and supports eight bitwise operations. Each cycle it processes one SLICE-bit slice of the operands, under a start/busy/done handshake. It sits beside the adder in the ALU, and the controller reads F and zero when done pulses.

---
 rtl/seq_logic_unit_pkg.sv | 21 ++
 rtl/logic_slice.sv | 49 ++++
 rtl/seq_logic_unit.sv | 132 +++++++++++++
 tb/tb_seq_logic_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_logic_unit_pkg.sv
// Shared constants for the sequential logic unit: op codes and FSM encodings.
package seq_logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR   = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise unit built per bit from gate primitives.
module logic_slice
  import seq_logic_unit_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [SLICE-1:0] y
);

  logic [SLICE-1:0] y_and;
  logic [SLICE-1:0] y_or;
  logic [SLICE-1:0] y_xor;
  logic [SLICE-1:0] y_nor;
  logic [SLICE-1:0] y_nand;
  logic [SLICE-1:0] y_xnor;
  logic [SLICE-1:0] y_andn;
  logic [SLICE-1:0] b_n;

  for (genvar i = 0; i < int'(SLICE); i++) begin : g_bit
    and  u_and  (y_and[i],  a[i], b[i]);
    or   u_or   (y_or[i],   a[i], b[i]);
    xor  u_xor  (y_xor[i],  a[i], b[i]);
    nor  u_nor  (y_nor[i],  a[i], b[i]);
    nand u_nand (y_nand[i], a[i], b[i]);
    xnor u_xnor (y_xnor[i], a[i], b[i]);
    not  u_bn   (b_n[i],    b[i]);
    and  u_andn (y_andn[i], a[i], b_n[i]);
  end

  // Op select over the per-bit gate outputs.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = y_and;
      OP_OR:    y = y_or;
      OP_XOR:   y = y_xor;
      OP_NOR:   y = y_nor;
      OP_NAND:  y = y_nand;
      OP_XNOR:  y = y_xnor;
      OP_ANDN:  y = y_andn;
      OP_PASSA: y = a;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per cycle under start/busy/done.
module seq_logic_unit
  import seq_logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] y_sl;

  // Slice multiplexer indexed by the counter.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      if (cnt_q == CNT_W'(s)) begin
        a_sl = a_q[s*SLICE +: SLICE];
        b_sl = b_q[s*SLICE +: SLICE];
      end
    end
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_q),
    .y  (y_sl)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    f_d     = f_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int unsigned s = 0; s < NSLICE; s++) begin
          if (cnt_q == CNT_W'(s)) acc_d[s*SLICE +: SLICE] = y_sl;
        end
        // F/zero only see the accumulator once every slice is written.
        if (cnt_q == CNT_LAST) begin
          f_d     = acc_d;
          zero_d  = (acc_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign F    = f_q;
  assign zero = zero_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed self-checking bench for seq_logic_unit (WIDTH=32, SLICE=8).
module tb_seq_logic_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] F;
  logic        zero;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  seq_logic_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .F     (F),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until done shows, accumulating busy cycles and F movement.
  task automatic wait_done(input logic [31:0] f_prev, output int n, output int busy_n,
                           output logic f_moved);
    n = 0;
    busy_n = 0;
    f_moved = 1'b0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      if (F !== f_prev) f_moved = 1'b1;
      tick();
      n++;
    end
  endtask

  // Launch one op and return at the done cycle; latency/busy/F-hold checked.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    int n, busy_n;
    logic f_moved;
    logic [31:0] f_prev;
    f_prev = F;
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(f_prev, n, busy_n, f_moved);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_busy"}, 32'(busy_n), 32'd4);
    chk({tag, "_fhold"}, 32'(f_moved), 32'd0);
  endtask

  localparam logic [31:0] ALL_EXP [8] = '{
    32'h05A005A0, 32'hAFF5AFF5, 32'hAA55AA55, 32'h500A500A,
    32'hFA5FFA5F, 32'h55AA55AA, 32'hA005A005, 32'hA5A5A5A5
  };

  initial begin
    int n, busy_n, done_cnt;
    logic f_moved;

    rst = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0;

    // Reset and idle
    tick(); tick();
    rst = 1'b0;
    chk("rst_F", F, 32'h0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy || F != 0) done_cnt++;
    end
    chk("idle_quiet", 32'(done_cnt), 32'd0);

    // AND basic
    do_op("and", 3'b000, 32'hFFFF0000, 32'h0F0F0F0F);
    chk("and_F", F, 32'h0F0F0000);
    chk("and_zero", 32'(zero), 32'd0);
    chk("and_busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("and_done_pulse", 32'(done), 32'd0);
    chk("and_F_held", F, 32'h0F0F0000);

    // All eight ops
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("op%0d", i), 3'(i), 32'hA5A5A5A5, 32'h0FF00FF0);
      chk($sformatf("op%0d_F", i), F, ALL_EXP[i]);
      tick();
    end

    // Zero flag with an ignored start during RUN
    op = 3'b010; A = 32'h12345678; B = 32'h12345678; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 3'b001; A = 32'hFFFFFFFF; B = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        done_cnt++;
        chk("xor_F", F, 32'h0);
        chk("xor_zero", 32'(zero), 32'd1);
      end
      tick();
    end
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);
    chk("ign_busy_after", 32'(busy), 32'd0);

    // Back-to-back: start held in the done cycle
    do_op("b2b1", 3'b000, 32'h0000FFFF, 32'h0000F0F0);
    chk("b2b1_F", F, 32'h0000F0F0);
    op = 3'b001; A = 32'h1; B = 32'h2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_no_idle", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done(32'h0000F0F0, n, busy_n, f_moved);
    chk("b2b_gap", 32'(n + 1), 32'd5);
    chk("b2b_fhold", 32'(f_moved), 32'd0);
    chk("b2b2_F", F, 32'h3);
    tick();

    // Reset mid-operation
    op = 3'b111; A = 32'hDEADBEEF; B = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_F", F, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd0);
    tick(); tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    do_op("post", 3'b010, 32'hF0F0F0F0, 32'hFF00FF00);
    chk("post_F", F, 32'h0FF00FF0);
    chk("post_zero", 32'(zero), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
